ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequencer and two-way arbiter that shares the single-port RAM (`N`-bit address, `M`-bit data, synchronous write, combinational read) between two requesters. It owns the RAM's `write_enable`, address and `data_in` pins, serialises accesses through a three-state FSM, and returns registered read data with a one-cycle acknowledge. It sits directly in front of the RAM instance; requesters never touch the RAM pins.

## Interface
- `N`, 6: address width; must match the RAM.
- `M`, 32: data width; must match the RAM.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request from requester 0 / 1.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  N  access address.
- `wdata0` / `wdata1`  in  M  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  M  registered read data; valid while an ack for a read is high.
- `busy`  out  1  high when the FSM is not in IDLE.
- `ram_we`  out  1  to RAM `write_enable`.
- `ram_addr`  out  N  to RAM address.
- `ram_din`  out  M  to RAM `data_in`.
- `ram_dout`  in  M  from RAM `data_out`.

## Operation
- Requester protocol:
  - Assert `reqX` with `weX`, `addrX` and `wdataX`.
  - Hold all four stable until the cycle in which `ackX` is high.
  - `reqX` may stay high after ack with new fields for a back-to-back access.
- FSM: IDLE, GRANT, RESP.
  - IDLE: if any `req` is high, register the winner in `gnt_id`, go to GRANT. Otherwise stay.
  - GRANT: drive the RAM from the winner's inputs. `ram_we` = winner's `we`.
    - On the closing edge the RAM writes, or `rdata` captures `ram_dout` for a read.
    - `ack[gnt_id]` is registered high; go to RESP.
  - RESP: the ack is visible this cycle. All `req` inputs are ignored. Go to IDLE.
- Arbitration when both requests are high in IDLE is round-robin: the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- A single requester is granted immediately, regardless of the pointer. The pointer updates on every grant.
- Outside GRANT: `ram_we`=0, `ram_addr`=0, `ram_din`=0.
- A write leaves `rdata` unchanged.
- Dropping `reqX` during GRANT is a protocol violation. The access completes anyway.

## Timing
- Reset values:
  - state=IDLE, `ack0`=`ack1`=0, `busy`=0, `rdata`=0, `ram_we`=0, pointer=1.
- Reset mid-access: `ram_we` drops combinationally on `rst_n` low, so no write occurs. The pending ack is lost. RAM contents are not reset.
- Latency: `req` sampled high in IDLE at edge 0 → GRANT in cycle 1 → ack and `rdata` valid in cycle 2.
- Throughput: one access per 3 cycles. With continuous contention the two requesters alternate.
- Maximum wait for the losing requester: 3 cycles after its rival's grant.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`:
  - Defined: requester 0 always wins a tie. The pointer is not implemented, and requester 1 can starve.
  - Undefined (default): round-robin as above.

## Structure
- Package `ram_arb_pkg` holds:
  - the state enum typedef `ram_arb_state_t` (IDLE, GRANT, RESP);
  - the localparams `REQ0_ID`=0 and `REQ1_ID`=1.
- One sub-module, `ram_arb_pick`: combinational winner select from `req0`, `req1` and the pointer. The macro changes only this sub-module.
- Top level: FSM, grant register, RAM-port mux and `rdata` register.

## Test plan
- Reset with both reqs high and `rst_n` low: all outputs 0, `ram_we` never pulses. Release reset: requester 0 is granted first.
- Requester 0 writes 0xDEADBEEF to 0x05, then reads 0x05:
  - `ram_we` high for exactly one cycle;
  - `ack0` 2 cycles after each request;
  - `rdata`=0xDEADBEEF during the second ack.
- Both requesters hold req continuously (r0 reads 0x01, r1 reads 0x02, preloaded 0x11 and 0x22): grants alternate 0,1,0,1, each ack carries the correct value, period 3 cycles.
- Requester 1 writes 0x3F=0xA5A5A5A5 while requester 0 requests one cycle later: r1 acks first and r0 is granted in the following IDLE.
- Assert `rst_n` low during GRANT of a write to 0x10: location 0x10 keeps its old value, no ack, FSM in IDLE.
- With `RAM_ARB_FIXED_PRIO_EN` defined and both reqs held high: `ack1` never asserts over 30 cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and requester identifiers for the two-way single-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } ram_arb_state_t;

    localparam logic REQ0_ID = 1'b0;
    localparam logic REQ1_ID = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between the two requesters.
// RAM_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins a tie and last_gnt is ignored.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic any_req,
    output logic winner
);

    always_comb begin
        any_req = req0 | req1;
        winner  = REQ0_ID;
        if (req0 && req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            winner = REQ0_ID;
`else
            // Tie goes to whoever was not granted last.
            winner = ~last_gnt;
`endif
        end else if (req1) begin
            winner = REQ1_ID;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Sequencer/arbiter owning the pins of a single-port RAM shared by two requesters.
// Tie-break policy selectable with RAM_ARB_FIXED_PRIO_EN (see ram_arb_pick).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N = 6,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [M-1:0] wdata0,
    input  logic [M-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic [M-1:0] rdata,
    output logic         busy,
    output logic         ram_we,
    output logic [N-1:0] ram_addr,
    output logic [M-1:0] ram_din,
    input  logic [M-1:0] ram_dout
);

    ram_arb_state_t state_reg, state_next;
    logic           gnt_id_reg, gnt_id_next;
    logic           last_gnt_reg, last_gnt_next;
    logic [1:0]     ack_reg;
    logic [M-1:0]   rdata_reg;

    logic           any_req;
    logic           winner;
    logic           in_grant;
    logic           sel_we;
    logic [N-1:0]   sel_addr;
    logic [M-1:0]   sel_wdata;

    ram_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_reg),
        .any_req  (any_req),
        .winner   (winner)
    );

    always_comb begin
        state_next    = state_reg;
        gnt_id_next   = gnt_id_reg;
        last_gnt_next = last_gnt_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    gnt_id_next   = winner;
                    last_gnt_next = winner;
                end
            end
            GRANT:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_grant  = (state_reg == GRANT);
    assign sel_we    = (gnt_id_reg == REQ1_ID) ? we1    : we0;
    assign sel_addr  = (gnt_id_reg == REQ1_ID) ? addr1  : addr0;
    assign sel_wdata = (gnt_id_reg == REQ1_ID) ? wdata1 : wdata0;

    // Gating with rst_n keeps a write from landing on the edge that follows a mid-access reset.
    assign ram_we   = in_grant & sel_we & rst_n;
    assign ram_addr = in_grant ? sel_addr  : '0;
    assign ram_din  = in_grant ? sel_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            gnt_id_reg   <= REQ0_ID;
            last_gnt_reg <= REQ1_ID;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_id_reg   <= gnt_id_next;
            last_gnt_reg <= last_gnt_next;
            if (in_grant && !sel_we) begin
                rdata_reg <= ram_dout;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ack_reg[gi] <= 1'b0;
                end else begin
                    ack_reg[gi] <= in_grant && (gnt_id_reg == 1'(gi));
                end
            end
        end
    endgenerate

    assign ack0  = ack_reg[0];
    assign ack1  = ack_reg[1];
    assign rdata = rdata_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural single-port RAM and an ack scoreboard.
module tb_ram_arbiter;

    localparam int N = 6;
    localparam int M = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, we0, we1;
    logic [N-1:0] addr0, addr1;
    logic [M-1:0] wdata0, wdata1;
    logic         ack0, ack1, busy, ram_we;
    logic [M-1:0] rdata, ram_din, ram_dout;
    logic [N-1:0] ram_addr;

    ram_arbiter #(.N(N), .M(M)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata    (rdata),
        .busy     (busy),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read.
    logic [M-1:0] mem [64];
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard: one entry per expected ack, in grant order.
    typedef struct {
        bit           id;
        logic [M-1:0] rdata;
    } exp_t;
    exp_t         sb[$];
    logic [M-1:0] model_rd;
    int           ack_count = 0;
    int           we_count  = 0;
    int           ack_times[$];
    bit           prev_ack  = 1'b0;
    bit           sb_off    = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (ram_we) we_count++;
        if ((ack0 || ack1) && !sb_off) begin
            ack_count++;
            ack_times.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'({ack1, ack0}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_id", 64'({ack1, ack0}), e.id ? 64'd2 : 64'd1);
                check("ack_rdata", 64'(rdata), 64'(e.rdata));
            end
            check("ack_single_cycle", 64'(prev_ack), 64'd0);
        end
        prev_ack = ack0 | ack1;
    end

    task automatic push_exp(bit id, bit we, logic [M-1:0] rd);
        exp_t e;
        if (!we) model_rd = rd;
        e.id    = id;
        e.rdata = model_rd;
        sb.push_back(e);
    endtask

    task automatic drive(bit id, bit we, logic [N-1:0] a, logic [M-1:0] d);
        if (id) begin
            req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic undrive(bit id);
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acks(int n, int budget);
        int start = ack_count;
        for (int i = 0; i < budget && (ack_count - start) < n; i++) step();
        if ((ack_count - start) < n) check("ack_timeout", 64'(ack_count - start), 64'(n));
    endtask

    typedef struct {
        bit           id;
        bit           we;
        logic [N-1:0] addr;
        logic [M-1:0] wdata;
        logic [M-1:0] rd;
    } vec_t;
    vec_t tbl[8];

    task automatic run_access(vec_t v);
        int c0;
        ack_times.delete();
        we_count = 0;
        push_exp(v.id, v.we, v.rd);
        drive(v.id, v.we, v.addr, v.wdata);
        c0 = cyc;
        wait_acks(1, 10);
        undrive(v.id);
        if (ack_times.size() > 0) check("access_latency", 64'(ack_times[0] - c0), 64'd2);
        check("access_we_cycles", 64'(we_count), v.we ? 64'd1 : 64'd0);
        step();
    endtask

    initial begin
        int c0;
        int seen;
        bit exp_id;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1]  = 32'h11;
        mem[2]  = 32'h22;
        mem[16] = 32'h55AA55AA;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_rd = '0;

        tbl[0] = '{1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 6'h3F, 32'h0F0F0F0F, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 6'h3F, 32'h0,        32'h0F0F0F0F};
        tbl[4] = '{1'b0, 1'b0, 6'h3F, 32'h0,        32'h0F0F0F0F};
        tbl[5] = '{1'b1, 1'b1, 6'h00, 32'h12345678, 32'h0};
        tbl[6] = '{1'b0, 1'b0, 6'h00, 32'h0,        32'h12345678};
        tbl[7] = '{1'b1, 1'b0, 6'h05, 32'h0,        32'hDEADBEEF};

        // Reset held with both requesters active: everything quiet.
        drive(1'b0, 1'b0, 6'h01, '0);
        drive(1'b1, 1'b0, 6'h02, '0);
        we_count = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("reset_ctrl", 64'({ack0, ack1, busy, ram_we, ram_addr}), 64'd0);
            check("reset_data", {ram_din, rdata}, 64'd0);
        end
        check("reset_no_we", 64'(we_count), 64'd0);

        // Release: requester 0 wins the first tie, requester 1 follows.
        push_exp(1'b0, 1'b0, 32'h11);
        push_exp(1'b1, 1'b0, 32'h22);
        ack_times.delete();
        rst_n = 1'b1;
        c0 = cyc;
        wait_acks(1, 10);
        undrive(1'b0);
        wait_acks(1, 10);
        undrive(1'b1);
        if (ack_times.size() == 2) begin
            check("first_grant_latency", 64'(ack_times[0] - c0), 64'd2);
            check("second_grant_gap", 64'(ack_times[1] - ack_times[0]), 64'd3);
        end
        step();

        for (int i = 0; i < 8; i++) run_access(tbl[i]);

        // Continuous contention; the last grant went to requester 1, so 0 starts.
        ack_times.delete();
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = (i % 2) == 1;
`endif
            push_exp(exp_id, 1'b0, exp_id ? 32'h22 : 32'h11);
        end
        drive(1'b0, 1'b0, 6'h01, '0);
        drive(1'b1, 1'b0, 6'h02, '0);
        wait_acks(4, 30);
        undrive(1'b0);
        undrive(1'b1);
        for (int i = 1; i < ack_times.size(); i++)
            check("contention_period", 64'(ack_times[i] - ack_times[i-1]), 64'd3);
        step();

        // Requester 1 writes, requester 0 asks one cycle later and must see the new data.
        ack_times.delete();
        push_exp(1'b1, 1'b1, '0);
        push_exp(1'b0, 1'b0, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 6'h3F, 32'hA5A5A5A5);
        step();
        drive(1'b0, 1'b0, 6'h3F, '0);
        wait_acks(1, 10);
        undrive(1'b1);
        wait_acks(1, 10);
        undrive(1'b0);
        if (ack_times.size() == 2)
            check("late_req_gap", 64'(ack_times[1] - ack_times[0]), 64'd3);
        step();

        // Reset during the GRANT cycle of a write to 0x10.
        drive(1'b0, 1'b1, 6'h10, 32'hFFFFFFFF);
        step();
        check("grant_we_high", 64'(ram_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("reset_we_drop", 64'(ram_we), 64'd0);
        undrive(1'b0);
        we_count = 0;
        c0 = ack_count;
        step();
        step();
        check("reset_no_ack", 64'(ack_count - c0), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_we_count", 64'(we_count), 64'd0);
        check("reset_mem_kept", 64'(mem[16]), 64'h55AA55AA);
        rst_n = 1'b1;
        model_rd = '0;
        step();
        check("rdata_after_reset", 64'(rdata), 64'd0);
        run_access('{1'b0, 1'b0, 6'h10, 32'h0, 32'h55AA55AA});

`ifdef RAM_ARB_FIXED_PRIO_EN
        // Fixed priority: requester 1 starves under continuous contention.
        sb_off = 1'b1;
        seen = 0;
        drive(1'b0, 1'b0, 6'h01, '0);
        drive(1'b1, 1'b0, 6'h02, '0);
        for (int i = 0; i < 30; i++) begin
            step();
            if (ack1) seen++;
        end
        undrive(1'b0);
        undrive(1'b1);
        check("fixed_no_ack1", 64'(seen), 64'd0);
        step();
        step();
        sb_off = 1'b0;
`else
        seen = 0;
`endif

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
